deco_7seg_mux: RTL
==================

DECO_7SEG_MUX -- requirements
Module: deco_7seg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: 1 inverts o_Segmentos and o_DP.
REQ-004 Parameter AN_ACTIVE_LOW, default 1: 1 means the enabled anode is driven 0.
REQ-005 Port i_Clk, input, 1: the only clock; all state is updated on its rising edge.
REQ-006 Port i_Rst_n, input, 1: the block has one clock; reset is synchronous and active-low.
REQ-007 Port i_Valor, input, 4*NUM_DIGITS: hex nibbles; nibble k (bits 4k+3..4k) is digit k, and digit 0 is the rightmost.
REQ-008 Port i_DP, input, NUM_DIGITS: decimal-point request per digit.
REQ-009 Port i_Carga, input, 1: one-cycle load strobe that samples i_Valor and i_DP.
REQ-010 Port o_Segmentos, output, 7: bit6..bit0 = a,b,c,d,e,f,g.
REQ-011 Port o_DP, output, 1: decimal point of the active digit.
REQ-012 Port o_Anodos, output, NUM_DIGITS: one-hot digit enable.
REQ-013 Port o_Ocupado, output, 1: a load is pending and is not yet displayed.

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; its wrap cycle is the slot tick.
REQ-015 On each slot tick, the digit index SHALL advance by 1; from NUM_DIGITS-1 it SHALL wrap to 0 (frame boundary).
REQ-016 When i_Carga=1, the block SHALL copy i_Valor and i_DP into a pending buffer and set o_Ocupado=1 on the next edge.
REQ-017 At the frame boundary with a pending load, the display register SHALL take the pending buffer, and o_Ocupado SHALL clear on the same edge.
REQ-018 i_Carga during o_Ocupado=1 SHALL overwrite the pending buffer; only the latest value is displayed.
REQ-019 If i_Carga coincides with the frame boundary, the incoming value SHALL be captured as pending, not applied, and applies at the next boundary.
REQ-020 The decoder SHALL produce active-high codes 0-F as: 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
REQ-021 o_Segmentos, o_DP and o_Anodos SHALL be registered, lagging the digit index and display register by exactly 1 cycle.
REQ-022 Exactly one anode SHALL be active at any time after the first post-reset cycle; no two-anode overlap is permitted.
REQ-023 When NUM_DIGITS=1, the index SHALL stay 0 and every slot tick SHALL be a frame boundary.

Reset
REQ-024 While i_Rst_n=0 at a rising edge, all of the following SHALL clear: prescaler, index, display register, pending buffer and o_Ocupado.
REQ-025 The same reset SHALL drive o_Segmentos and o_DP to all-off and o_Anodos to all-inactive (polarity per parameters).
REQ-026 The first edge after release SHALL output digit 0 showing "0" (7E).
REQ-027 Reset with a load pending SHALL discard the load.

Configuration
REQ-028 With macro DECO_7SEG_MUX_BLANK_EN defined, digit k>0 SHALL be blanked (segments all-off, anode still scanned) when nibbles k..NUM_DIGITS-1 are all 0.
REQ-029 With DECO_7SEG_MUX_BLANK_EN defined, o_DP for a blanked digit SHALL still follow i_DP.
REQ-030 Without DECO_7SEG_MUX_BLANK_EN, every digit SHALL show its hex code, including leading zeros.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1)
REQ-031 Reset, then release -> o_Anodos=1110 and o_Segmentos=7E one cycle later; the index advances every 4 cycles, with anodes 1101, 1011, 0111, then 1110.
REQ-032 Load i_Valor=16'h12AF mid-frame -> o_Ocupado=1 until the frame boundary; the next frame shows digit0..3 = 47,77,6D,30.
REQ-033 Load 16'h1111 then 16'h2222 within one frame -> only 6D is shown on all digits; 30 never appears.
REQ-034 i_Carga on the boundary cycle -> o_Ocupado stays 1 for one full frame (16 cycles); the value applies at the following boundary.
REQ-035 DECO_7SEG_MUX_BLANK_EN defined, load 16'h0050 with i_DP=4'b1000 -> digit3 segments 00 with o_DP=1, digit2 00, digit1 5B, digit0 7E; without the macro, digits 3 and 2 show 7E.
REQ-036 Assert i_Rst_n=0 while o_Ocupado=1 -> after release, the display shows 0000 and o_Ocupado=0.

Source files
------------

// File: rtl/deco_7seg_mux.sv
// Multiplexed hex 7-segment driver with double-buffered load; display updates only at frame boundaries.
// Optional leading-zero blanking is enabled by defining DECO_7SEG_MUX_BLANK_EN.
module deco_7seg_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_Valor,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_Carga,
  output logic [6:0]              o_Segmentos,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_Anodos,
  output logic                    o_Ocupado
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              nib;
  logic                    dp_cur;
  logic                    blank_cur;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'h7E;
      4'h1: seg_code = 7'h30;
      4'h2: seg_code = 7'h6D;
      4'h3: seg_code = 7'h79;
      4'h4: seg_code = 7'h33;
      4'h5: seg_code = 7'h5B;
      4'h6: seg_code = 7'h5F;
      4'h7: seg_code = 7'h70;
      4'h8: seg_code = 7'h7F;
      4'h9: seg_code = 7'h7B;
      4'hA: seg_code = 7'h77;
      4'hB: seg_code = 7'h1F;
      4'hC: seg_code = 7'h4E;
      4'hD: seg_code = 7'h3D;
      4'hE: seg_code = 7'h4F;
      default: seg_code = 7'h47;
    endcase
  endfunction

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load on the boundary edge becomes pending; the older pending value (if any) is what gets displayed.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      o_Ocupado <= 1'b0;
    end else begin
      if (boundary && o_Ocupado) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      if (i_Carga) begin
        pend_val  <= i_Valor;
        pend_dp   <= i_DP;
        o_Ocupado <= 1'b1;
      end else if (boundary) begin
        o_Ocupado <= 1'b0;
      end
    end
  end

`ifdef DECO_7SEG_MUX_BLANK_EN
  logic zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    nib       = '0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    onehot    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = disp_val[4*k +: 4];
        dp_cur    = disp_dp[k];
        blank_cur = blank[k];
        onehot[k] = 1'b1;
      end
    end
  end

  // XOR with the all-off pattern applies the configured output polarity.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      o_Segmentos <= SEG_OFF;
      o_DP        <= DP_OFF;
      o_Anodos    <= AN_OFF;
    end else begin
      o_Segmentos <= (blank_cur ? 7'h00 : seg_code(nib)) ^ SEG_OFF;
      o_DP        <= dp_cur ^ DP_OFF;
      o_Anodos    <= onehot ^ AN_OFF;
    end
  end

endmodule
